instr_realigner: RTL
====================

INSTR_REALIGNER -- requirements
Module: instr_realigner

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_HW, default 4, halfword buffer depth (fixed at 4; other values unsupported).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, [1:0]=2'b00.
REQ-007 imem_valid  input  1  imem_rdata valid for current request, same cycle.
REQ-008 imem_rdata  input  32  fetched word, little-endian halfwords.
REQ-009 redirect  input  1  flush and restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new PC, [0] ignored.
REQ-011 out_valid  output  1  out_instr/out_pc/out_is_compressed valid.
REQ-012 out_ready  input  1  downstream (decompressor/decode) accepts.
REQ-013 out_instr  output  32  aligned raw instruction; [31:16]=0 when compressed.
REQ-014 out_is_compressed  output  1  out_instr[15:0] is a 16-bit instruction.
REQ-015 out_pc  output  32  PC of out_instr.

Function
REQ-016 Block shall hold a 4-entry halfword FIFO (count 0..4), a fetch PC (fpc) and an output PC (opc).
REQ-017 imem_req shall be 1 when count<=2 and no redirect this cycle; imem_addr={fpc[31:2],2'b00}.
REQ-018 On imem_req&&imem_valid, both halfwords shall be pushed (low first) and fpc += 4.
REQ-019 FSM states ALIGNED and SKIP_HALF; SKIP_HALF entered on redirect with redirect_pc[1]=1.
REQ-020 In SKIP_HALF, next accepted word shall push only rdata[31:16] (count+1), then go to ALIGNED.
REQ-021 Head halfword with [1:0]!=2'b11 shall be compressed: out_valid when count>=1.
REQ-022 Head halfword with [1:0]==2'b11 shall be 32-bit: out_valid only when count>=2; out_instr={hw1,hw0}.
REQ-023 On out_valid&&out_ready, pop 1 (compressed) or 2 halfwords and opc += 2 or 4.
REQ-024 Push and pop in same cycle shall both take effect; count = count + pushed - popped.
REQ-025 Outputs shall be combinational from FIFO head; zero added latency beyond the registered FIFO: word accepted in cycle N -> out_valid in N+1.
REQ-026 out_* shall stay stable while out_valid && !out_ready.
REQ-027 redirect shall win over all same-cycle push/pop: FIFO cleared, fetched word discarded, fpc={redirect_pc[31:2],2'b00}, opc={redirect_pc[31:1],1'b0}; out_valid=0 that cycle and next.
REQ-028 PC arithmetic shall wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-029 A 32-bit instruction spanning two words shall be emitted only after both words arrive, with out_pc of its first halfword.

Reset
REQ-030 On reset: count=0, FSM=ALIGNED if RESET_PC[1]=0 else SKIP_HALF, fpc={RESET_PC[31:2],2'b00}, opc={RESET_PC[31:1],1'b0}.
REQ-031 During reset: out_valid=0, imem_req=0, out_instr=0, out_is_compressed=0; imem_req may assert on first edge after release.
REQ-032 Reset asserted mid-transfer shall discard all buffered halfwords without emitting them.

Configuration
REQ-033 Macro REALIGN_RVC_EN: defined -> behaviour above.
REQ-034 Not defined -> every instruction 32-bit, out_is_compressed=0, pop 2 per handshake, redirect_pc[1] and RESET_PC[1] ignored (SKIP_HALF unused), opc += 4.

Verification
REQ-035 Reset, RESET_PC=0, words 32'h00A00093, 32'h00B00113 -> out (00A00093, pc 0, c=0), (00B00113, pc 4, c=0).
REQ-036 Word 32'h4505_0505 -> two compressed outs: 32'h0000_0505 pc 0, 32'h0000_4505 pc 2.
REQ-037 Words 32'h0093_4505, 32'h0000_00A0 -> out 32'h0000_4505 pc 0, then spanning 32'h00A0_0093 pc 2 one cycle after 2nd word.
REQ-038 redirect, redirect_pc=32'h0000_0102 -> imem_addr=0x100, low half of returned word dropped, first out_pc=0x102.
REQ-039 out_ready=0 for 5 cycles with 4 halfwords buffered -> imem_req=0, out_* stable; release -> in-order drain, no loss.
REQ-040 redirect asserted in same cycle as out handshake and imem_valid -> no pop counted, word dropped, count=0 next cycle.

Source files
------------

// File: rtl/instr_realigner.sv
// Realigns a word-wide instruction fetch stream into 16/32-bit instructions through a 4-halfword FIFO.
// Define REALIGN_RVC_EN to enable compressed instructions; without it every instruction is 32-bit.
module instr_realigner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_compressed,
  output logic [31:0] out_pc
);

`ifdef REALIGN_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif

  typedef enum logic {ALIGNED, SKIP_HALF} state_t;

  localparam state_t      RESET_STATE = (RVC_EN && RESET_PC[1]) ? SKIP_HALF : ALIGNED;
  localparam logic [31:0] RESET_OPC   = RVC_EN ? {RESET_PC[31:1], 1'b0} : {RESET_PC[31:2], 2'b00};

  logic [15:0] hw_q [BUF_HW];
  logic [15:0] hw_d [BUF_HW];
  logic [2:0]  count_q, count_d;
  logic [31:0] fpc_q, opc_q;
  state_t      state_q;
  logic        head_is_c, head_ok, fire_in, skip;
  logic [1:0]  push_n, pop_n, base;
  logic        unused_pc0;

  assign unused_pc0 = redirect_pc[0];

  assign head_is_c = RVC_EN && (hw_q[0][1:0] != 2'b11);
  assign head_ok   = head_is_c ? (count_q >= 3'd1) : (count_q >= 3'd2);
  assign out_valid = !reset && !redirect && head_ok;
  assign imem_req  = !reset && !redirect && (count_q <= 3'd2);
  assign imem_addr = {fpc_q[31:2], 2'b00};

  assign fire_in = imem_req && imem_valid;
  assign skip    = (state_q == SKIP_HALF);
  assign push_n  = !fire_in ? 2'd0 : (skip ? 2'd1 : 2'd2);
  assign pop_n   = !(out_valid && out_ready) ? 2'd0 : (head_is_c ? 2'd1 : 2'd2);
  // Tail slot after this cycle's pop; a push only happens with count<=2, so base+1 never overflows.
  assign base    = count_q[1:0] - pop_n;
  assign count_d = count_q + {1'b0, push_n} - {1'b0, pop_n};

  assign out_is_compressed = out_valid && head_is_c;
  assign out_instr = !out_valid ? '0 :
                     head_is_c  ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
  assign out_pc    = opc_q;

  // Head is always slot 0: pop shifts down, push appends after the surviving entries.
  always_comb begin
    hw_d = hw_q;
    case (pop_n)
      2'd1:    hw_d = '{hw_q[1], hw_q[2], hw_q[3], hw_q[3]};
      2'd2:    hw_d = '{hw_q[2], hw_q[3], hw_q[2], hw_q[3]};
      default: hw_d = hw_q;
    endcase
    if (push_n == 2'd1) begin
      hw_d[base] = imem_rdata[31:16];
    end else if (push_n == 2'd2) begin
      hw_d[base]         = imem_rdata[15:0];
      hw_d[base + 2'd1]  = imem_rdata[31:16];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hw_q    <= '{default: '0};
      count_q <= '0;
      state_q <= RESET_STATE;
      fpc_q   <= {RESET_PC[31:2], 2'b00};
      opc_q   <= RESET_OPC;
    end else if (redirect) begin
      count_q <= '0;
      state_q <= (RVC_EN && redirect_pc[1]) ? SKIP_HALF : ALIGNED;
      fpc_q   <= {redirect_pc[31:2], 2'b00};
      opc_q   <= RVC_EN ? {redirect_pc[31:1], 1'b0} : {redirect_pc[31:2], 2'b00};
    end else begin
      hw_q    <= hw_d;
      count_q <= count_d;
      opc_q   <= opc_q + {29'd0, pop_n, 1'b0};
      if (fire_in) begin
        fpc_q   <= fpc_q + 32'd4;
        state_q <= ALIGNED;
      end
    end
  end

endmodule
